iob_pk: RTL

- Command decoder upstream of the control-panel unit.
- Takes raw bytes from the IOBUS UART receiver and parses the panel command protocol.
- Drives the panel's `keys`/`keys_trig`, `rotary_in`/`rotary_trig` and `fn`/`fn_v`/`fn_trig` inputs.
- On request, returns a two-byte snapshot of the panel indicators to the UART transmitter.

---
 rtl/iob_pk.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/iob_pk.sv
// iob_pk: parses the IOBUS UART command protocol into control-panel key, rotary and function strobes.
// Define IOB_PK_ACK_EN to queue a one-byte 8'h80 ack for every completed FN/ROT/KEYS command.
module iob_pk #(
    parameter int unsigned CLK_SYS_HZ = 50_000_000,
    parameter int unsigned TIMEOUT_MS = 10
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [0:9]  indicators,
    output logic [0:15] keys,
    output logic        keys_trig,
    output logic [0:3]  rotary_in,
    output logic        rotary_trig,
    output logic [0:3]  fn,
    output logic        fn_v,
    output logic        fn_trig,
    output logic        err
);

    localparam int unsigned TO_LOAD = CLK_SYS_HZ / 1000 * TIMEOUT_MS;
    localparam int unsigned TO_W    = (TO_LOAD > 1) ? $clog2(TO_LOAD + 1) : 1;
    localparam logic [TO_W-1:0] TO_LOAD_W = TO_W'(TO_LOAD);

    localparam logic [1:0] OP_FN   = 2'b00;
    localparam logic [1:0] OP_ROT  = 2'b01;
    localparam logic [1:0] OP_KEYS = 2'b10;

    typedef enum logic [1:0] {IDLE, KP0, KP1, KP2} rx_state_t;
    typedef enum logic [1:0] {
        TX_IDLE, TX_B1, TX_B2
`ifdef IOB_PK_ACK_EN
        , TX_ACK
`endif
    } tx_state_t;

    rx_state_t       rx_state, rx_state_nx;
    tx_state_t       tx_state, tx_state_nx;
    logic [0:13]     keys_sh, keys_sh_nx;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
    logic [7:0]      b2_q, b2_nx;

    logic [0:15] keys_nx;
    logic [0:3]  rotary_nx, fn_nx;
    logic        fn_v_nx, keys_trig_nx, rotary_trig_nx, fn_trig_nx;
    logic [7:0]  tx_data_nx;
    logic        tx_valid_nx;
    logic        rx_err, tx_err, status_req;

`ifdef IOB_PK_ACK_EN
    logic [1:0] ack_cnt, ack_cnt_nx;
    logic       ack_dec, ack_inc;
`endif

    // A command byte always restarts decoding, even in the middle of a KEYS payload.
    always_comb begin
        rx_state_nx    = rx_state;
        keys_sh_nx     = keys_sh;
        to_cnt_nx      = to_cnt;
        keys_nx        = keys;
        keys_trig_nx   = 1'b0;
        rotary_nx      = rotary_in;
        rotary_trig_nx = 1'b0;
        fn_nx          = fn;
        fn_v_nx        = fn_v;
        fn_trig_nx     = 1'b0;
        rx_err         = 1'b0;
        status_req     = 1'b0;
        if (rx_valid) begin
            if (rx_data[7]) begin
                if (rx_state != IDLE) rx_err = 1'b1;
                rx_state_nx = IDLE;
                case (rx_data[6:5])
                    OP_FN: begin
                        if (rx_data[3:0] <= 4'd11) begin
                            fn_nx      = rx_data[3:0];
                            fn_v_nx    = rx_data[4];
                            fn_trig_nx = 1'b1;
                        end else begin
                            rx_err = 1'b1;
                        end
                    end
                    OP_ROT: begin
                        rotary_nx      = rx_data[3:0];
                        rotary_trig_nx = 1'b1;
                    end
                    OP_KEYS: begin
                        rx_state_nx = KP0;
                        to_cnt_nx   = TO_LOAD_W;
                    end
                    default: status_req = 1'b1;
                endcase
            end else begin
                to_cnt_nx = TO_LOAD_W;
                case (rx_state)
                    IDLE: rx_err = 1'b1;
                    KP0: begin
                        keys_sh_nx[0:6] = rx_data[6:0];
                        rx_state_nx     = KP1;
                    end
                    KP1: begin
                        keys_sh_nx[7:13] = rx_data[6:0];
                        rx_state_nx      = KP2;
                    end
                    default: begin
                        keys_nx      = {keys_sh, rx_data[1:0]};
                        keys_trig_nx = 1'b1;
                        rx_state_nx  = IDLE;
                    end
                endcase
            end
        end else if (rx_state != IDLE && TO_LOAD != 0) begin
            if (to_cnt == '0) begin
                rx_state_nx = IDLE;
                rx_err      = 1'b1;
            end else begin
                to_cnt_nx = to_cnt - TO_W'(1);
            end
        end
    end

    // Reply path: a status snapshot is taken on acceptance and streamed out as B1 then B2.
    always_comb begin
        tx_state_nx = tx_state;
        tx_data_nx  = tx_data;
        tx_valid_nx = tx_valid;
        b2_nx       = b2_q;
        tx_err      = 1'b0;
`ifdef IOB_PK_ACK_EN
        ack_dec     = 1'b0;
`endif
        case (tx_state)
            TX_IDLE: begin
                if (status_req) begin
                    tx_state_nx = TX_B1;
                    tx_data_nx  = {5'b11100, indicators[0:2]};
                    tx_valid_nx = 1'b1;
                    b2_nx       = {1'b0, indicators[3:9]};
                end
`ifdef IOB_PK_ACK_EN
                else if (ack_cnt != 2'd0) begin
                    tx_state_nx = TX_ACK;
                    tx_data_nx  = 8'h80;
                    tx_valid_nx = 1'b1;
                    ack_dec     = 1'b1;
                end
`endif
            end
            TX_B1: begin
                if (tx_ready) begin
                    tx_state_nx = TX_B2;
                    tx_data_nx  = b2_q;
                end
            end
            TX_B2: begin
                if (tx_ready) begin
                    tx_state_nx = TX_IDLE;
                    tx_data_nx  = 8'h00;
                    tx_valid_nx = 1'b0;
                end
            end
`ifdef IOB_PK_ACK_EN
            TX_ACK: begin
                if (tx_ready) begin
                    tx_state_nx = TX_IDLE;
                    tx_data_nx  = 8'h00;
                    tx_valid_nx = 1'b0;
                end
            end
`endif
            default: tx_state_nx = TX_IDLE;
        endcase
        if (status_req && tx_state != TX_IDLE) tx_err = 1'b1;
    end

`ifdef IOB_PK_ACK_EN
    // Saturating ack backlog; overflowing acks are silently lost.
    always_comb begin
        ack_inc    = fn_trig_nx | rotary_trig_nx | keys_trig_nx;
        ack_cnt_nx = ack_cnt - {1'b0, ack_dec};
        if (ack_inc && ack_cnt_nx != 2'd3) ack_cnt_nx = ack_cnt_nx + 2'd1;
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            rx_state    <= IDLE;
            tx_state    <= TX_IDLE;
            keys_sh     <= '0;
            to_cnt      <= '0;
            b2_q        <= '0;
            keys        <= '0;
            keys_trig   <= 1'b0;
            rotary_in   <= '0;
            rotary_trig <= 1'b0;
            fn          <= '0;
            fn_v        <= 1'b0;
            fn_trig     <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            err         <= 1'b0;
`ifdef IOB_PK_ACK_EN
            ack_cnt     <= '0;
`endif
        end else begin
            rx_state    <= rx_state_nx;
            tx_state    <= tx_state_nx;
            keys_sh     <= keys_sh_nx;
            to_cnt      <= to_cnt_nx;
            b2_q        <= b2_nx;
            keys        <= keys_nx;
            keys_trig   <= keys_trig_nx;
            rotary_in   <= rotary_nx;
            rotary_trig <= rotary_trig_nx;
            fn          <= fn_nx;
            fn_v        <= fn_v_nx;
            fn_trig     <= fn_trig_nx;
            tx_data     <= tx_data_nx;
            tx_valid    <= tx_valid_nx;
            err         <= rx_err | tx_err;
`ifdef IOB_PK_ACK_EN
            ack_cnt     <= ack_cnt_nx;
`endif
        end
    end

endmodule
